fifo_reader: RTL and testbench
==============================

# fifo_reader

Read-side consumer engine for the synchronous FIFO. It issues `rd_en` only when the FIFO is non-empty and local space is guaranteed, captures `data_out` one cycle later, and presents words on a valid/ready stream with no loss under backpressure. It sits between the FIFO's read port and any downstream consumer, in place of the bench's manual read driving.

## Interface
Parameters:
- `FIFO_WIDTH`, default 16: data word width.
- `FIFO_DEPTH`, default 8: depth of the attached FIFO. Informational; it sizes nothing here.
- `SKID_DEPTH`, default 2: local buffer entries. Legal range is ≥2, power of two.

Ports:
- `clk`, input, 1: sole clock. Everything is on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `en`, input, 1: run request. Level-sensitive.
- `empty`, input, 1: from the FIFO.
- `underflow`, input, 1: from the FIFO.
- `data_out`, input, FIFO_WIDTH: FIFO read data. Valid the cycle after an accepted `rd_en`.
- `rd_en`, output, 1: FIFO read request. Combinational.
- `m_valid`, output, 1: downstream word valid. Registered.
- `m_data`, output, FIFO_WIDTH: downstream word. Head of the skid buffer.
- `m_ready`, input, 1: downstream accept.
- `busy`, output, 1: state ≠ IDLE.
- `err`, output, 1: sticky. Set if `underflow` is seen while this block drives `rd_en`.
- `rd_count`, output, 16: words delivered downstream. Wraps at 2^16.

## Operation
- States are IDLE, ACTIVE and STOPPING.
  - IDLE → ACTIVE when `en`=1.
  - ACTIVE → STOPPING when `en`=0.
  - STOPPING → IDLE when `inflight`=0 and the skid buffer is empty.
  - STOPPING → ACTIVE when `en`=1 again.
- `pop` = `m_valid && m_ready`.
- `rd_en` = (state==ACTIVE) && !`empty` && (`occ` + `inflight` − `pop`) < SKID_DEPTH.
  - `rd_en` is never asserted while `empty`=1.
  - The arithmetic is done at width clog2(SKID_DEPTH)+1 bits.
- `inflight` (0..1): set at the edge where `rd_en`=1, cleared one edge later when `data_out` is captured. Issue and capture in the same cycle leave it at 1.
- Skid buffer is a FIFO-ordered ring: write pointer, read pointer, `occ` counter.
  - Write occurs when `inflight`=1, capturing `data_out`.
  - Read occurs on `pop`.
  - Simultaneous write and read leave `occ` unchanged.
  - Pointers wrap modulo SKID_DEPTH.
  - The credit rule guarantees no overflow. An overflow is a design bug and carries an assertion.
- `m_valid` = (`occ` ≠ 0). `m_data` = entry[rd_ptr]. `m_data` is held stable while `m_valid`=1 and `m_ready`=0.
- `rd_count` increments by 1 on each `pop`.
- `err` sets when `underflow`=1 in the cycle after `rd_en`=1, and holds until reset.
- Words issued before `en` falls are always delivered; none are dropped in STOPPING.

## Timing
- Reset values:
  - state = IDLE.
  - `rd_en`=0, `m_valid`=0, `m_data`=0, `busy`=0, `err`=0, `rd_count`=0.
  - `occ`, `inflight` and both pointers = 0.
- Latency:
  - `en` sampled high at edge E0 → state ACTIVE after E0 → first `rd_en` in that cycle (cycle 1).
  - `rd_en` in cycle n → `data_out` valid in cycle n+1 → `m_valid`=1 in cycle n+2.
  - `en`-to-`m_valid` is 3 cycles minimum.
- Throughput: with `m_ready`=1 and a non-empty FIFO, `rd_en` is asserted every cycle and one word/cycle is delivered. This holds at SKID_DEPTH=2.
- Backpressure: `m_ready`=0 stalls `rd_en` within 1 cycle. At most SKID_DEPTH words are buffered.
- Reset asserted mid-operation: all state clears immediately, and words buffered or in flight are discarded.

## Structure
- Shared package `fifo_pkg` holds:
  - `FIFO_WIDTH_DEF`=16 and `FIFO_DEPTH_DEF`=8.
  - `typedef enum logic [1:0] {IDLE, ACTIVE, STOPPING} rd_state_e`.
- Sub-module `fifo_reader_skid` contains the ring buffer, pointers, `occ`, and the `m_valid`/`m_data` outputs. The top contains the FSM, the credit logic, `inflight`, `err` and `rd_count`.

## Test plan
- **Reset:** assert `rd_n`=0 asynchronously mid-cycle → all outputs go to 0 at once, before the next edge; `busy`=0.
- **Streaming:** FIFO preloaded with 0x0001..0x0008, `m_ready`=1, `en` high at edge 0 → `rd_en` in cycles 1–8; `m_data` 0x0001..0x0008 in cycles 3–10; `rd_count`=8; `rd_en` drops when `empty`=1.
- **Backpressure:** same preload, `m_ready`=0 from cycle 4 to 12 → `rd_en` low while `occ`=2; `m_data` held at 0x0002; after release, 0x0002..0x0008 arrive in order with no gap or duplicate.
- **Stop:** `en` dropped the cycle after a `rd_en` → that word is still delivered; state goes STOPPING then IDLE; `busy` falls after `occ`=0; no further `rd_en`.
- **Error:** force `underflow`=1 the cycle after `rd_en` → `err`=1 and stays 1 until `rst_n`.
- **Mid-stream reset:** `rst_n` pulsed with `occ`=2 → `m_valid`=0 and `rd_count`=0; a subsequent run delivers only fresh FIFO words.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side blocks: default sizes and the
// reader engine state encoding.
package fifo_pkg;

  localparam int unsigned FIFO_WIDTH_DEF = 16;
  localparam int unsigned FIFO_DEPTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    STOPPING
  } rd_state_e;

endpackage

// File: rtl/fifo_reader_if.sv
// FIFO read port plus downstream valid/ready stream, as seen by fifo_reader.
// master = the reader engine, slave = the FIFO and consumer side.
interface fifo_reader_if
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = FIFO_WIDTH_DEF
) ();

  logic             rd_en;
  logic             empty;
  logic             underflow;
  logic [WIDTH-1:0] data_out;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;

  modport master (
    output rd_en, m_valid, m_data,
    input  empty, underflow, data_out, m_ready
  );

  modport slave (
    input  rd_en, m_valid, m_data,
    output empty, underflow, data_out, m_ready
  );

endinterface

// File: rtl/fifo_reader_skid.sv
// Ring buffer that absorbs FIFO read data and presents the oldest word on
// the downstream stream; m_valid is a registered view of occupancy.
module fifo_reader_skid
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = FIFO_WIDTH_DEF,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic                       m_valid,
  output logic [WIDTH-1:0]           m_data,
  output logic [$clog2(DEPTH):0]     occ
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    occ_next;

  always_comb begin
    occ_next = occ;
    case ({wr_en, pop})
      2'b10:   occ_next = occ + 1'b1;
      2'b01:   occ_next = occ - 1'b1;
      default: occ_next = occ;
    endcase
  end

  // Pointers are PW bits wide, so wrap modulo DEPTH falls out of the width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem     <= '{default: '0};
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      occ     <= '0;
      m_valid <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      occ     <= occ_next;
      m_valid <= (occ_next != '0);
    end
  end

  assign m_data = mem[rd_ptr];

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(wr_en && !pop && (occ == CW'(DEPTH))));

endmodule

// File: rtl/fifo_reader.sv
// FIFO read-side consumer: issues rd_en only with guaranteed local space,
// captures data_out a cycle later and streams it out on valid/ready.
module fifo_reader
  import fifo_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int unsigned SKID_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  fifo_reader_if.master bus,
  output logic          busy,
  output logic          err,
  output logic [15:0]   rd_count
);

  localparam int unsigned CW = $clog2(SKID_DEPTH) + 1;

  if (SKID_DEPTH < 2 || (SKID_DEPTH & (SKID_DEPTH - 1)) != 0 || FIFO_DEPTH < 1) begin : g_param_check
    $error("fifo_reader: SKID_DEPTH must be a power of two >= 2 and FIFO_DEPTH >= 1");
  end

  rd_state_e             state;
  rd_state_e             state_next;
  logic                  inflight;
  logic                  pop;
  logic                  rd_en;
  logic                  m_valid;
  logic [FIFO_WIDTH-1:0] m_data;
  logic [CW-1:0]         occ;
  logic [CW-1:0]         credit;

  assign pop    = m_valid && bus.m_ready;
  // Space committed after this edge: buffered + in flight, less the word leaving now.
  assign credit = occ + CW'(inflight) - CW'(pop);
  assign rd_en  = (state == ACTIVE) && !bus.empty && (credit < CW'(SKID_DEPTH));

  assign bus.rd_en   = rd_en;
  assign bus.m_valid = m_valid;
  assign bus.m_data  = m_data;
  assign busy        = (state != IDLE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (en) state_next = ACTIVE;
      ACTIVE:   if (!en) state_next = STOPPING;
      STOPPING: begin
        if (en)                          state_next = ACTIVE;
        else if (!inflight && occ == '0) state_next = IDLE;
      end
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 1'b0;
      err      <= 1'b0;
      rd_count <= '0;
    end else begin
      inflight <= rd_en;
      if (inflight && bus.underflow) begin
        err <= 1'b1;
      end
      if (pop) begin
        rd_count <= rd_count + 16'd1;
      end
    end
  end

  fifo_reader_skid #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (SKID_DEPTH)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (inflight),
    .wr_data (bus.data_out),
    .pop     (pop),
    .m_valid (m_valid),
    .m_data  (m_data),
    .occ     (occ)
  );

endmodule

// File: tb/tb_fifo_reader.sv
// Self-checking bench for fifo_reader: cycle tables for streaming and
// backpressure, hand sequences for stop/error/reset, then random traffic.
module tb_fifo_reader;
  import fifo_pkg::*;

  localparam int unsigned W  = 16;
  localparam int unsigned SD = 2;

  typedef struct {
    logic        m_ready;
    logic        rd_en;
    logic        m_valid;
    logic [15:0] m_data;
    logic [15:0] count;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        uf = 1'b0;
  logic        m_ready_t = 1'b0;
  logic        busy;
  logic        err;
  logic [15:0] rd_count;

  logic [W-1:0] mem [256];
  int           wr_i = 0;
  int           rd_i = 0;
  logic [W-1:0] fdata = '0;

  int           errors = 0;
  int           checks = 0;
  logic [W-1:0] exp_q [$];
  logic [15:0]  mcnt = '0;
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data = '0;
  vec_t         tbl [$];

  always #5 clk = ~clk;

  fifo_reader_if #(.WIDTH(W)) bus ();

  assign bus.empty     = (wr_i == rd_i);
  assign bus.underflow = uf;
  assign bus.data_out  = fdata;
  assign bus.m_ready   = m_ready_t;

  fifo_reader #(
    .FIFO_WIDTH (W),
    .FIFO_DEPTH (8),
    .SKID_DEPTH (SD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .bus      (bus.master),
    .busy     (busy),
    .err      (err),
    .rd_count (rd_count)
  );

  // Behavioural FIFO: read data appears the cycle after an accepted rd_en.
  always @(posedge clk) begin
    if (bus.rd_en && wr_i != rd_i) begin
      fdata <= mem[rd_i[7:0]];
      rd_i  <= rd_i + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required < 200000", $time);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [W-1:0] v);
    mem[wr_i[7:0]] = v;
    wr_i++;
  endtask

  // Reference: every word read from the FIFO is delivered once, in read order.
  task automatic monitor();
    logic [W-1:0] e;
    chk("rd_en_while_empty", bus.rd_en & bus.empty, 0);
    chk("rd_count_model", rd_count, mcnt);
    if (prev_stall) chk("stall_hold", {bus.m_valid, bus.m_data}, {1'b1, prev_data});
    if (bus.m_valid && m_ready_t) begin
      chk("sb_word_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_data", bus.m_data, e);
      end
      mcnt = mcnt + 16'd1;
    end
    if (bus.rd_en && !bus.empty) exp_q.push_back(mem[rd_i[7:0]]);
    chk("skid_bound", exp_q.size() <= SD, 1);
    prev_stall = bus.m_valid && !m_ready_t;
    prev_data  = bus.m_data;
  endtask

  task automatic cyc_end();
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    @(negedge clk);
    cyc_end();
  endtask

  task automatic clear_model();
    exp_q.delete();
    mcnt       = '0;
    prev_stall = 1'b0;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    en        = 1'b0;
    uf        = 1'b0;
    m_ready_t = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  function automatic vec_t mk(logic mr, logic re, logic mv, logic [15:0] d, logic [15:0] cnt);
    vec_t v;
    v.m_ready = mr; v.rd_en = re; v.m_valid = mv; v.m_data = d; v.count = cnt;
    return v;
  endfunction

  task automatic run_table(input string name);
    logic [33:0] act;
    logic [33:0] exp;
    push_words(16'h0001, 8);
    en        = 1'b1;
    m_ready_t = 1'b1;
    step();
    for (int unsigned c = 0; c < tbl.size(); c++) begin
      m_ready_t = tbl[c].m_ready;
      @(negedge clk);
      act = {bus.rd_en, bus.m_valid, bus.m_valid ? bus.m_data : 16'h0, rd_count};
      exp = {tbl[c].rd_en, tbl[c].m_valid, tbl[c].m_data, tbl[c].count};
      chk($sformatf("%s_cycle%0d", name, c + 1), act, exp);
      cyc_end();
    end
  endtask

  task automatic push_words(input logic [W-1:0] first, input int n);
    for (int i = 0; i < n; i++) push(first + W'(i));
  endtask

  initial begin
    logic [W-1:0] fresh_head;
    logic         seen;

    // Reset values
    #3;
    chk("reset_outputs", {bus.rd_en, bus.m_valid, bus.m_data, busy, err, rd_count}, 0);
    do_reset();

    // Streaming: 8 words, consumer always ready
    tbl.delete();
    for (int c = 1; c <= 12; c++)
      tbl.push_back(mk(1'b1, c <= 8, c >= 3 && c <= 10,
                       (c >= 3 && c <= 10) ? 16'(c - 2) : 16'h0,
                       (c <= 3) ? 16'h0 : ((c >= 11) ? 16'd8 : 16'(c - 3))));
    run_table("stream");

    // Backpressure: consumer stalls in cycles 4..12
    do_reset();
    tbl.delete();
    for (int c = 1; c <= 20; c++)
      tbl.push_back(mk(c < 4 || c > 12, c <= 3 || (c >= 13 && c <= 17), c >= 3 && c <= 19,
                       (c == 3) ? 16'h1 : ((c >= 4 && c <= 13) ? 16'h2 : ((c >= 14 && c <= 19) ? 16'(c - 11) : 16'h0)),
                       (c <= 3) ? 16'h0 : ((c <= 13) ? 16'h1 : 16'(c - 12))));
    run_table("backpressure");

    // Stop: en dropped the cycle after the first rd_en
    do_reset();
    push_words(16'h0010, 8);
    en = 1'b1; m_ready_t = 1'b1;
    step();
    @(negedge clk); chk("stop_rd_en_c1", bus.rd_en, 1); cyc_end();
    en = 1'b0;
    @(negedge clk); chk("stop_rd_en_c2", bus.rd_en, 1); cyc_end();
    @(negedge clk); chk("stop_c3", {bus.rd_en, busy, bus.m_valid, bus.m_data}, {3'b011, 16'h0010}); cyc_end();
    @(negedge clk); chk("stop_c4", {bus.m_valid, bus.m_data}, {1'b1, 16'h0011}); cyc_end();
    @(negedge clk); chk("stop_c5", {bus.m_valid, busy}, 2'b01); cyc_end();
    @(negedge clk); chk("stop_idle", {busy, rd_count}, {1'b0, 16'd2}); cyc_end();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk("stop_no_rd_en", bus.rd_en, 0); cyc_end();
    end

    // Error: underflow ignored without a read, sticky after one
    push_words(16'h0020, 16);
    uf = 1'b1; step(); uf = 1'b0;
    @(negedge clk); chk("err_idle_underflow", err, 0); cyc_end();
    en = 1'b1; m_ready_t = 1'b1;
    step();
    @(negedge clk); chk("err_rd_en", bus.rd_en, 1); cyc_end();
    uf = 1'b1; step(); uf = 1'b0;
    @(negedge clk); chk("err_set", err, 1); cyc_end();
    repeat (5) step();
    @(negedge clk); chk("err_sticky", err, 1); cyc_end();

    // Mid-stream reset with the skid buffer full
    m_ready_t = 1'b0;
    repeat (4) step();
    @(negedge clk); chk("full_stall", {bus.m_valid, bus.rd_en}, 2'b10); cyc_end();
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", {bus.rd_en, bus.m_valid, bus.m_data, busy, err, rd_count}, 0);
    en = 1'b0;
    clear_model();
    @(posedge clk);
    #1 rst_n = 1'b1;
    fresh_head = mem[rd_i[7:0]];
    en = 1'b1; m_ready_t = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!seen && bus.m_valid) begin
        chk("fresh_first_word", bus.m_data, fresh_head);
        seen = 1'b1;
      end
      cyc_end();
    end
    chk("fresh_word_seen", seen, 1);

    // Random traffic against the scoreboard
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(2) == 0 && (wr_i - rd_i) < 200) push(W'($urandom));
      m_ready_t = ($urandom_range(3) != 0);
      if ($urandom_range(15) == 0) en = !en;
      step();
    end
    en = 1'b1; m_ready_t = 1'b1;
    for (int i = 0; i < 300 && !(bus.empty && exp_q.size() == 0); i++) step();
    chk("drain_done", bus.empty && exp_q.size() == 0, 1);
    en = 1'b0;
    for (int i = 0; i < 10 && busy; i++) step();
    chk("idle_after_drain", busy, 0);
    chk("final_count", rd_count, mcnt);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
